mvu_inst_seq: RTL and testbench

MVU_INST_SEQ -- requirements
Module: mvu_inst_seq

---
 rtl/mvu_inst_seq.sv | 148 ++++++++++++++
 tb/tb_mvu_inst_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mvu_inst_seq.sv
// rtl/mvu_inst_seq.sv - MVU macro-instruction to per-chunk micro-instruction sequencer
`ifndef VRFAW
`define VRFAW 9
`endif
`ifndef MRFAW
`define MRFAW 9
`endif
`ifndef VRFIDW
`define VRFIDW 3
`endif
`ifndef NTAGW
`define NTAGW 5
`endif
`ifndef QDEPTH
`define QDEPTH 4
`endif

module mvu_inst_seq #(
    parameter int VRFAW  = `VRFAW,
    parameter int MRFAW  = `MRFAW,
    parameter int VRFIDW = `VRFIDW,
    parameter int NTAGW  = `NTAGW,
    parameter int QDEPTH = `QDEPTH,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_minst_valid,
    output logic              o_minst_ready,
    input  logic [VRFAW-1:0]  i_vrf_base,
    input  logic [VRFIDW-1:0] i_vrf_id,
    input  logic              i_reg_sel,
    input  logic [MRFAW-1:0]  i_mrf_base,
    input  logic [NTAGW-1:0]  i_tag,
    input  logic [CNTW-1:0]   i_nchunk,
    input  logic [4:0]        i_acc_size,
    input  logic              i_vrf_en,
    output logic              o_uinst_valid,
    input  logic              i_uinst_ready,
    output logic [VRFAW-1:0]  o_vrf_rd_addr,
    output logic [VRFIDW-1:0] o_vrf_rd_id,
    output logic              o_reg_sel,
    output logic [MRFAW-1:0]  o_mrf_rd_addr,
    output logic [NTAGW-1:0]  o_tag,
    output logic [1:0]        o_acc_op,
    output logic [4:0]        o_acc_size,
    output logic              o_vrf_en,
    input  logic              i_tag_update_en,
    input  logic              i_wb_done,
    output logic              o_busy
);
    localparam int CRW = $clog2(QDEPTH) + 1;

    typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_t;

    state_t            state, state_nxt;
    logic [VRFAW-1:0]  vrf_base_r;
    logic [VRFIDW-1:0] vrf_id_r;
    logic              reg_sel_r;
    logic [MRFAW-1:0]  mrf_base_r;
    logic [NTAGW-1:0]  tag_r;
    logic [CNTW-1:0]   n_r;
    logic [4:0]        acc_size_r;
    logic              vrf_en_r;
    logic [CNTW-1:0]   k_r;
    logic [NTAGW-1:0]  cur_tag;
    logic [CRW-1:0]    credit;

    logic tag_all_ones, tag_ok, last, is_wb, issue_ok;
    logic minst_hs, uinst_hs, credit_inc;

    assign tag_all_ones = &tag_r;
    assign tag_ok       = tag_all_ones || (cur_tag >= tag_r);
    assign last         = (k_r == n_r - CNTW'(1));

    always_comb begin
        o_acc_op = 2'd1;
        if (n_r == CNTW'(1))
            o_acc_op = 2'd3;
        else if (k_r == '0)
            o_acc_op = 2'd0;
        else if (last)
            o_acc_op = 2'd2;
    end

    // Writebacks need a free output FIFO slot unless untagged (all-ones tag)
    assign is_wb         = o_acc_op[1];
    assign issue_ok      = !is_wb || (credit < CRW'(QDEPTH)) || tag_all_ones;
    assign o_uinst_valid = (state == ISSUE) && issue_ok;
    assign o_minst_ready = (state == IDLE);
    assign o_busy        = (state != IDLE);
    assign minst_hs      = i_minst_valid && o_minst_ready;
    assign uinst_hs      = o_uinst_valid && i_uinst_ready;
    assign credit_inc    = uinst_hs && is_wb && !tag_all_ones;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_minst_valid) state_nxt = HOLD;
            HOLD:    if (tag_ok) state_nxt = ISSUE;
            ISSUE:   if (uinst_hs && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k_r     <= '0;
            credit  <= '0;
            cur_tag <= '0;
        end else begin
            state <= state_nxt;
            if (minst_hs)
                k_r <= '0;
            else if (uinst_hs)
                k_r <= k_r + CNTW'(1);
            if (i_tag_update_en)
                cur_tag <= cur_tag + NTAGW'(1);
            if (credit_inc && !i_wb_done)
                credit <= credit + CRW'(1);
            else if (!credit_inc && i_wb_done && credit != '0)
                credit <= credit - CRW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (minst_hs) begin
            vrf_base_r <= i_vrf_base;
            vrf_id_r   <= i_vrf_id;
            reg_sel_r  <= i_reg_sel;
            mrf_base_r <= i_mrf_base;
            tag_r      <= i_tag;
            n_r        <= (i_nchunk == '0) ? CNTW'(1) : i_nchunk;
            acc_size_r <= i_acc_size;
            vrf_en_r   <= i_vrf_en;
        end
    end

    assign o_vrf_rd_addr = vrf_base_r + VRFAW'(k_r);
    assign o_mrf_rd_addr = mrf_base_r + MRFAW'(k_r);
    assign o_vrf_rd_id   = vrf_id_r;
    assign o_reg_sel     = reg_sel_r;
    assign o_tag         = tag_r;
    assign o_acc_size    = acc_size_r;
    assign o_vrf_en      = vrf_en_r;

endmodule

// File: tb/tb_mvu_inst_seq.sv
// tb/tb_mvu_inst_seq.sv - directed self-checking bench for mvu_inst_seq
module tb_mvu_inst_seq;
    localparam int VRFAW = 9, MRFAW = 9, VRFIDW = 3, NTAGW = 5, QDEPTH = 4, CNTW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_minst_valid;
    logic              o_minst_ready;
    logic [VRFAW-1:0]  i_vrf_base;
    logic [VRFIDW-1:0] i_vrf_id;
    logic              i_reg_sel;
    logic [MRFAW-1:0]  i_mrf_base;
    logic [NTAGW-1:0]  i_tag;
    logic [CNTW-1:0]   i_nchunk;
    logic [4:0]        i_acc_size;
    logic              i_vrf_en;
    logic              o_uinst_valid;
    logic              i_uinst_ready;
    logic [VRFAW-1:0]  o_vrf_rd_addr;
    logic [VRFIDW-1:0] o_vrf_rd_id;
    logic              o_reg_sel;
    logic [MRFAW-1:0]  o_mrf_rd_addr;
    logic [NTAGW-1:0]  o_tag;
    logic [1:0]        o_acc_op;
    logic [4:0]        o_acc_size;
    logic              o_vrf_en;
    logic              i_tag_update_en;
    logic              i_wb_done;
    logic              o_busy;

    int checks = 0;
    int failures = 0;

    mvu_inst_seq #(
        .VRFAW(VRFAW), .MRFAW(MRFAW), .VRFIDW(VRFIDW),
        .NTAGW(NTAGW), .QDEPTH(QDEPTH), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_minst_valid(i_minst_valid), .o_minst_ready(o_minst_ready),
        .i_vrf_base(i_vrf_base), .i_vrf_id(i_vrf_id), .i_reg_sel(i_reg_sel),
        .i_mrf_base(i_mrf_base), .i_tag(i_tag), .i_nchunk(i_nchunk),
        .i_acc_size(i_acc_size), .i_vrf_en(i_vrf_en),
        .o_uinst_valid(o_uinst_valid), .i_uinst_ready(i_uinst_ready),
        .o_vrf_rd_addr(o_vrf_rd_addr), .o_vrf_rd_id(o_vrf_rd_id), .o_reg_sel(o_reg_sel),
        .o_mrf_rd_addr(o_mrf_rd_addr), .o_tag(o_tag), .o_acc_op(o_acc_op),
        .o_acc_size(o_acc_size), .o_vrf_en(o_vrf_en),
        .i_tag_update_en(i_tag_update_en), .i_wb_done(i_wb_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic micro(input string tag, input int va, input int ma, input int op);
        check({tag, " valid"}, 32'(o_uinst_valid), 32'd1);
        check({tag, " vrf"}, 32'(o_vrf_rd_addr), 32'(va));
        check({tag, " mrf"}, 32'(o_mrf_rd_addr), 32'(ma));
        check({tag, " op"}, 32'(o_acc_op), 32'(op));
    endtask

    task automatic send(input int vb, input int mb, input int tg, input int n);
        i_vrf_base    = VRFAW'(vb);
        i_mrf_base    = MRFAW'(mb);
        i_tag         = NTAGW'(tg);
        i_nchunk      = CNTW'(n);
        i_vrf_id      = 3'd5;
        i_reg_sel     = 1'b1;
        i_acc_size    = 5'd17;
        i_vrf_en      = 1'b1;
        i_minst_valid = 1'b1;
        check("minst_ready", 32'(o_minst_ready), 32'd1);
        tick();
        i_minst_valid = 1'b0;
        check("busy in hold", 32'(o_busy), 32'd1);
        check("no valid in hold", 32'(o_uinst_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_minst_valid = 0; i_uinst_ready = 1; i_tag_update_en = 0; i_wb_done = 0;
        i_vrf_base = '0; i_mrf_base = '0; i_tag = '0; i_nchunk = '0;
        i_vrf_id = '0; i_reg_sel = 0; i_acc_size = '0; i_vrf_en = 0;
        tick(); tick();
        check("rst valid", 32'(o_uinst_valid), 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        tick();
        check("post-rst minst_ready", 32'(o_minst_ready), 32'd1);
        check("post-rst credit", 32'(dut.credit), 32'd0);

        // N=3, untagged, ready high
        send(10, 100, 31, 3);
        tick(); micro("n3 k0", 10, 100, 0);
        check("n3 tag", 32'(o_tag), 32'd31);
        check("n3 id", 32'(o_vrf_rd_id), 32'd5);
        check("n3 acc_size", 32'(o_acc_size), 32'd17);
        check("n3 reg_sel", 32'(o_reg_sel), 32'd1);
        check("n3 vrf_en", 32'(o_vrf_en), 32'd1);
        tick(); micro("n3 k1", 11, 101, 1);
        tick(); micro("n3 k2", 12, 102, 2);
        tick();
        check("n3 done valid", 32'(o_uinst_valid), 32'd0);
        check("n3 done busy", 32'(o_busy), 32'd0);
        check("n3 credit", 32'(dut.credit), 32'd0);

        // Tag wait: N=1, tag 2, current_tag 0
        send(1, 2, 2, 1);
        tick(); tick();
        check("tagwait valid", 32'(o_uinst_valid), 32'd0);
        i_tag_update_en = 1; tick(); tick(); i_tag_update_en = 0;
        check("tagwait still held", 32'(o_uinst_valid), 32'd0);
        tick(); micro("tag op3", 1, 2, 3);
        tick();
        check("tag credit", 32'(dut.credit), 32'd1);
        check("tag idle", 32'(o_minst_ready), 32'd1);

        // Fill credit to QDEPTH with three more WB micros (nchunk 0 acts as 1)
        for (int i = 0; i < 3; i++) begin
            send(i, i, 2, 0);
            tick(); check("fill op", 32'(o_acc_op), 32'd3);
            tick();
        end
        check("credit full", 32'(dut.credit), 32'd4);
        send(50, 60, 2, 2);
        tick(); micro("full set", 50, 60, 0);
        tick();
        check("full wb held", 32'(o_uinst_valid), 32'd0);
        tick();
        check("full wb still held", 32'(o_uinst_valid), 32'd0);
        i_wb_done = 1; tick(); i_wb_done = 0;
        check("credit after done", 32'(dut.credit), 32'd3);
        micro("released wb", 51, 61, 2);
        tick();
        check("credit refilled", 32'(dut.credit), 32'd4);

        // Back-pressure on a 4-chunk untagged macro
        i_uinst_ready = 0;
        send(20, 40, 31, 4);
        tick(); micro("bp k0", 20, 40, 0);
        tick(); micro("bp k0 stall", 20, 40, 0);
        i_uinst_ready = 1; tick(); micro("bp k1", 21, 41, 1);
        i_uinst_ready = 0; tick(); micro("bp k1 stall", 21, 41, 1);
        i_uinst_ready = 1; tick(); micro("bp k2", 22, 42, 1);
        tick(); micro("bp k3", 23, 43, 2);
        i_uinst_ready = 0; tick(); micro("bp k3 stall", 23, 43, 2);
        i_uinst_ready = 1; tick();
        check("bp done", 32'(o_uinst_valid), 32'd0);
        check("bp credit", 32'(dut.credit), 32'd4);

        i_wb_done = 1; tick(); tick(); tick(); i_wb_done = 0;
        check("credit drained to 1", 32'(dut.credit), 32'd1);

        // Address wrap and simultaneous WB handshake with wb_done
        send(511, 5, 2, 2);
        tick(); micro("wrap k0", 511, 5, 0);
        tick(); micro("wrap k1", 0, 6, 2);
        i_wb_done = 1; tick(); i_wb_done = 0;
        check("simul credit", 32'(dut.credit), 32'd1);
        i_wb_done = 1; tick(); tick(); i_wb_done = 0;
        check("credit floor", 32'(dut.credit), 32'd0);

        // Reset mid-macro
        send(70, 80, 31, 5);
        tick(); micro("rst k0", 70, 80, 0);
        tick(); micro("rst k1", 71, 81, 1);
        tick(); micro("rst k2", 72, 82, 1);
        rst = 1; tick();
        check("midrst valid", 32'(o_uinst_valid), 32'd0);
        check("midrst busy", 32'(o_busy), 32'd0);
        check("midrst credit", 32'(dut.credit), 32'd0);
        rst = 0; tick();
        check("midrst ready", 32'(o_minst_ready), 32'd1);
        tick();
        check("midrst no resume", 32'(o_uinst_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
